// File: rtl/hwpe_ctrl_regfile_arbiter.sv
// Round-robin arbiter sharing the HWPE control register file read/write port pair
// between N_REQ TCDM-style requesters, with a 1-cycle registered response path.
module hwpe_ctrl_regfile_arbiter #(
  parameter int unsigned N_REQ      = 2,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_BYTE   = DATA_WIDTH / 8,
  parameter int unsigned ID_WIDTH   = $clog2(N_REQ)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                clear,
  input  logic [N_REQ-1:0]                    req_i,
  input  logic [N_REQ-1:0]                    wen_i,
  input  logic [N_REQ-1:0][ADDR_WIDTH-1:0]    add_i,
  input  logic [N_REQ-1:0][DATA_WIDTH-1:0]    data_i,
  input  logic [N_REQ-1:0][NUM_BYTE-1:0]      be_i,
  output logic [N_REQ-1:0]                    gnt_o,
  output logic [N_REQ-1:0]                    r_valid_o,
  output logic [DATA_WIDTH-1:0]               r_data_o,
  output logic                                rf_read_enable_o,
  output logic [ADDR_WIDTH-1:0]               rf_read_addr_o,
  input  logic [DATA_WIDTH-1:0]               rf_read_data_i,
  output logic                                rf_write_enable_o,
  output logic [ADDR_WIDTH-1:0]               rf_write_addr_o,
  output logic [DATA_WIDTH-1:0]               rf_write_data_o,
  output logic [NUM_BYTE-1:0]                 rf_write_be_o
);

  localparam int unsigned SumWidth = ID_WIDTH + 1;

  logic [ID_WIDTH-1:0] ptr_q, ptr_d;
  logic [ID_WIDTH-1:0] r_id_q, r_id_d;
  logic                r_pend_q, r_pend_d;
  logic                r_is_read_q, r_is_read_d;

  logic                gnt_valid;
  logic [ID_WIDTH-1:0] gnt_idx;
  logic [SumWidth-1:0] scan_sum;
  logic [ID_WIDTH-1:0] scan_idx;

  // Scan from ptr_q upwards, wrapping modulo N_REQ; the first requester found wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      scan_sum = {1'b0, ptr_q} + SumWidth'(k);
      if (scan_sum >= SumWidth'(N_REQ)) begin
        scan_sum = scan_sum - SumWidth'(N_REQ);
      end
      scan_idx = scan_sum[ID_WIDTH-1:0];
      if (!gnt_valid && req_i[scan_idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = scan_idx;
      end
    end
    if (!rst_n || clear) begin
      gnt_valid = 1'b0;
    end
  end

  always_comb begin
    gnt_o             = '0;
    rf_read_enable_o  = 1'b0;
    rf_read_addr_o    = '0;
    rf_write_enable_o = 1'b0;
    rf_write_addr_o   = '0;
    rf_write_data_o   = '0;
    rf_write_be_o     = '0;
    if (gnt_valid) begin
      gnt_o = N_REQ'(1) << gnt_idx;
      if (wen_i[gnt_idx]) begin
        rf_write_enable_o = 1'b1;
        rf_write_addr_o   = add_i[gnt_idx];
        rf_write_data_o   = data_i[gnt_idx];
        rf_write_be_o     = be_i[gnt_idx];
      end else begin
        rf_read_enable_o = 1'b1;
        rf_read_addr_o   = add_i[gnt_idx];
      end
    end
  end

  // The register file returns read data one cycle after the address, so the response
  // data is passed straight through while the registered grant says it belongs to a read.
  always_comb begin
    r_valid_o = '0;
    r_data_o  = '0;
    if (rst_n && r_pend_q) begin
      r_valid_o = N_REQ'(1) << r_id_q;
      if (r_is_read_q) begin
        r_data_o = rf_read_data_i;
      end
    end
  end

  always_comb begin
    ptr_d       = ptr_q;
    r_pend_d    = gnt_valid;
    r_id_d      = r_id_q;
    r_is_read_d = r_is_read_q;
    if (gnt_valid) begin
      r_id_d      = gnt_idx;
      r_is_read_d = ~wen_i[gnt_idx];
      if (32'(gnt_idx) == N_REQ - 1) begin
        ptr_d = '0;
      end else begin
        ptr_d = gnt_idx + 1'b1;
      end
    end
    if (clear) begin
      ptr_d    = '0;
      r_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      r_pend_q    <= 1'b0;
      r_id_q      <= '0;
      r_is_read_q <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      r_pend_q    <= r_pend_d;
      r_id_q      <= r_id_d;
      r_is_read_q <= r_is_read_d;
    end
  end

endmodule
